// File: rtl/relu_maxpool_if.sv
// Bundle between relu_maxpool and its neighbours: start request, trimmed input
// array, pooled array and the per-window output stream.
interface relu_maxpool_if #(
  parameter int SIZE = 7,
  parameter int DW   = 32
);
  localparam int P  = SIZE / 2;
  localparam int RW = $clog2(P) + 1;

  logic                 en;
  logic signed [DW-1:0] TrimArray [SIZE][SIZE];
  logic signed [DW-1:0] PoolArray [P][P];
  logic signed [DW-1:0] out_data;
  logic [RW-1:0]        out_row;
  logic [RW-1:0]        out_col;
  logic                 out_valid;
  logic                 busy;
  logic                 done;

  modport master (
    output en, TrimArray,
    input  PoolArray, out_data, out_row, out_col, out_valid, busy, done
  );

  modport slave (
    input  en, TrimArray,
    output PoolArray, out_data, out_row, out_col, out_valid, busy, done
  );
endinterface

// File: rtl/relu_maxpool.sv
// ReLU + 2x2/stride-2 max pooling over a captured SIZE x SIZE frame, one
// element per clock, with a registered pooled array and a per-window stream.
module relu_maxpool #(
  parameter int SIZE = 7,
  parameter int DW   = 32
) (
  input  logic           clk,
  input  logic           reset,
  relu_maxpool_if.slave  io
);
  localparam int P  = SIZE / 2;
  localparam int RW = $clog2(P) + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] POOL = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]           state;
  logic [RW-1:0]        win_row;
  logic [RW-1:0]        win_col;
  logic [1:0]           elem_idx;
  logic signed [DW-1:0] run_max;
  logic signed [DW-1:0] frame_buf [SIZE][SIZE];

  logic signed [DW-1:0] elem;
  logic signed [DW-1:0] max_cur;
  logic signed [DW-1:0] max_next;

  // Ties keep the current value, so a zero floor makes ReLU implicit.
  function automatic logic signed [DW-1:0] sat_max(
    input logic signed [DW-1:0] cur,
    input logic signed [DW-1:0] cand
  );
    return (cand > cur) ? cand : cur;
  endfunction

  // Element order inside a window: top-left, top-right, bottom-left, bottom-right.
  always_comb begin
    elem = '0;
    for (int i = 0; i < SIZE; i++) begin
      for (int j = 0; j < SIZE; j++) begin
        if (i == 2 * int'(win_row) + int'(elem_idx[1]) &&
            j == 2 * int'(win_col) + int'(elem_idx[0]))
          elem = frame_buf[i][j];
      end
    end
    max_cur  = (elem_idx == 2'd0) ? '0 : run_max;
    max_next = sat_max(max_cur, elem);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      win_row      <= '0;
      win_col      <= '0;
      elem_idx     <= '0;
      run_max      <= '0;
      io.out_data  <= '0;
      io.out_row   <= '0;
      io.out_col   <= '0;
      io.out_valid <= 1'b0;
      io.busy      <= 1'b0;
      io.done      <= 1'b0;
      for (int i = 0; i < SIZE; i++)
        for (int j = 0; j < SIZE; j++)
          frame_buf[i][j] <= '0;
      for (int i = 0; i < P; i++)
        for (int j = 0; j < P; j++)
          io.PoolArray[i][j] <= '0;
    end else begin
      io.out_valid <= 1'b0;
      io.done      <= 1'b0;
      case (state)
        IDLE: begin
          io.busy <= io.en;
          if (io.en) begin
            frame_buf <= io.TrimArray;
            win_row   <= '0;
            win_col   <= '0;
            elem_idx  <= '0;
            state     <= POOL;
            for (int i = 0; i < P; i++)
              for (int j = 0; j < P; j++)
                io.PoolArray[i][j] <= '0;
          end
        end
        POOL: begin
          elem_idx <= elem_idx + 2'd1;
          run_max  <= max_next;
          if (elem_idx == 2'd3) begin
            for (int i = 0; i < P; i++)
              for (int j = 0; j < P; j++)
                if (i == int'(win_row) && j == int'(win_col))
                  io.PoolArray[i][j] <= max_next;
            io.out_data  <= max_next;
            io.out_row   <= win_row;
            io.out_col   <= win_col;
            io.out_valid <= 1'b1;
            if (win_col == RW'(P - 1)) begin
              win_col <= '0;
              if (win_row == RW'(P - 1))
                state <= DONE;
              else
                win_row <= win_row + 1'b1;
            end else begin
              win_col <= win_col + 1'b1;
            end
          end
        end
        // busy stays high through the done cycle and drops at the next IDLE edge.
        DONE: begin
          io.done <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/relu_maxpool.md
# relu_maxpool

Post-trim activation and pooling stage of the FFT convolution path. Consumes the SIZE×SIZE trimmed convolution result from the trimming stage, applies ReLU, and performs 2×2/stride-2 max pooling with one element read per clock. Produces both a registered pooled array and a per-window output stream for the next CNN layer.

## Interface

- SIZE, 7, side of the trimmed input array; legal range SIZE ≥ 2.
- DW, 32, element width, signed two's complement.
- P (localparam), SIZE/2 (floor), side of the pooled output array.

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  start request; sampled only in IDLE.
- TrimArray  in  DW × [SIZE][SIZE] (unpacked)  trimmed convolution result from the trimming stage.
- PoolArray  out  DW × [P][P] (unpacked)  registered pooled result.
- out_data  out  DW  pooled value of the window just completed.
- out_row, out_col  out  $clog2(P)+1 each  window coordinates of out_data.
- out_valid  out  1  one-cycle strobe qualifying out_data/out_row/out_col.
- busy  out  1  high from capture through DONE.
- done  out  1  one-cycle end-of-frame strobe.

## Operation

- FSM states: IDLE, POOL, DONE.
- IDLE: if en=1 at an edge, capture TrimArray into an internal buffer, clear PoolArray to 0, set window index (r,c)=(0,0) and element counter k=0, go to POOL. en=0 keeps IDLE.
- POOL: one buffered element per edge, k=0..3, in the order (2r,2c), (2r,2c+1), (2r+1,2c), (2r+1,2c+1).
  - The running max is initialised to 0 at k=0, so ReLU is implicit: result = max(0, four elements).
  - Compare is signed DW-bit. 0x80000000 is the most negative value; ties keep the current max.
- On the k=3 edge:
  - write PoolArray[r][c], out_data, out_row=r, out_col=c;
  - assert out_valid for the following cycle;
  - advance (r,c) in raster order, c fastest.
- After window (P-1,P-1) completes, go to DONE.
- DONE: assert done for one cycle, then go to IDLE.
- Odd SIZE: the last input row and column are never read.
- en while busy is ignored, with no queuing. en still high in IDLE after DONE starts a new frame; back-to-back operation is legal.
- TrimArray is read only at the capture edge. Later changes do not affect the frame in flight.
- PoolArray holds its values between frames until the next capture clears it.
- reset low, at any time including mid-frame: immediately IDLE; PoolArray, out_data, out_row, out_col, out_valid, busy, done, buffer and counters all 0. No partial output survives.

## Timing

- Edge 0 = the edge that samples en=1 in IDLE. busy=1 from after edge 0.
- Window w (0-based raster) completes at edge 4(w+1). out_valid is high exactly in the cycle after that edge. For SIZE=7 (P=3): edges 4, 8, …, 36.
- done is high in the cycle after edge 4P²+1. busy falls and state is IDLE after edge 4P²+2.
- Total frame = 4P²+2 cycles from capture to IDLE; earliest next capture edge is 4P²+2.
- out_valid and done are never high in the same cycle.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan

- Ramp, SIZE=7, TrimArray[i][j]=i+j, single en pulse → PoolArray[r][c]=2r+2c+2 ([0][0]=2, [2][2]=10). Nine out_valid strobes at edges 4..36 in raster order. done after edge 37.
- All-negative input (every element −5, plus one element 0x80000000) → every out_data=0 and PoolArray all 0 (ReLU).
- Max position sweep: per window, place value 100 in each of the 4 positions in turn, all other elements 1 → each out_data=100. Row 6 and column 6 set to 1000 → never appear in the output.
- Reset low at edge 10 mid-frame → all outputs 0 and state IDLE immediately. No further out_valid. A subsequent en runs a clean full frame.
- en held high continuously, input changed after the first capture edge → first frame uses only the captured data. Second capture occurs at edge 38 (SIZE=7) with new data. en pulses during busy have no effect.
- SIZE=2 instance → single window, out_valid after edge 4, done after edge 5, IDLE after edge 6.
